// File: rtl/operand_issue_fifo.sv
// Issue buffer in front of the stalling arithmetic pipe. Operand triples are
// queued in order and the head triple is presented to the pipe. The pipe
// consumes the head on every cycle where stall is low. Stalled cycles are
// counted, and the counter saturates.
module operand_issue_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_a_i,
  input  logic [WIDTH-1:0]         in_b_i,
  input  logic [WIDTH-1:0]         in_c_i,
  input  logic                     hold_i,
  output logic                     stall_o,
  output logic [WIDTH-1:0]         a_o,
  output logic [WIDTH-1:0]         b_o,
  output logic [WIDTH-1:0]         c_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              stall_cycles_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [WIDTH-1:0] mem_c_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  logic push, pop, empty;

  // Handshake, stall and head-output decode; outputs read zero while empty
  always_comb begin
    empty      = (count_q == '0);
    in_ready_o = (count_q != CountFull);
    stall_o    = hold_i || empty;
    push       = in_valid_i && in_ready_o;
    pop        = !stall_o;
    a_o        = '0;
    b_o        = '0;
    c_o        = '0;
    if (!empty) begin
      a_o = mem_a_q[rd_ptr_q];
      b_o = mem_b_q[rd_ptr_q];
      c_o = mem_c_q[rd_ptr_q];
    end
    count_o        = count_q;
    stall_cycles_o = stall_cnt_q;
  end

  // Next-state for pointers, occupancy and the saturating stall counter
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stall_cnt_d = stall_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (stall_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Storage write; contents are not reset, and the reset cycle writes nothing
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_a_q[wr_ptr_q] <= in_a_i;
      mem_b_q[wr_ptr_q] <= in_b_i;
      mem_c_q[wr_ptr_q] <= in_c_i;
    end
  end

`ifdef FORMAL
  initial assume (!rst_n);
`endif

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CountFull);
  a_ready: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready_o == (count_q != CountFull));
  a_stall: assert property (@(posedge clk) disable iff (!rst_n)
    stall_o == (hold_i || count_q == '0));
  a_empty_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (count_q == '0) |-> (a_o == '0 && b_o == '0 && c_o == '0));
  a_ptr_count: assert property (@(posedge clk) disable iff (!rst_n)
    PW'(wr_ptr_q - rd_ptr_q) == count_q[PW-1:0]);

endmodule

// File: tb/tb_operand_issue_fifo.sv
// Directed bench for operand_issue_fifo: reset, single push, fill under hold,
// streaming across pointer wrap, mid-operation reset and counter saturation.
module tb_operand_issue_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b, in_c;
  logic        hold;
  logic        stall;
  logic [15:0] a, b, c;
  logic [2:0]  count;
  logic [15:0] stall_cycles;

  int n_total = 0;
  int n_bad   = 0;

  operand_issue_fifo #(
    .WIDTH (16),
    .DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_a_i         (in_a),
    .in_b_i         (in_b),
    .in_c_i         (in_c),
    .hold_i         (hold),
    .stall_o        (stall),
    .a_o            (a),
    .b_o            (b),
    .c_o            (c),
    .count_o        (count),
    .stall_cycles_o (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ta, input logic [15:0] tb,
                       input logic [15:0] tc);
    in_valid = v;
    in_a     = ta;
    in_b     = tb;
    in_c     = tc;
  endtask

  task automatic check_head(input string tag, input int ea, input int eb, input int ec);
    check({tag, "_a"}, 32'(a), 32'(ea));
    check({tag, "_b"}, 32'(b), 32'(eb));
    check({tag, "_c"}, 32'(c), 32'(ec));
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 16'd0);

    // Reset values
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check_head("rst", 0, 0, 0);
    check("rst_scyc", 32'(stall_cycles), 32'd0);

    // Single push: visible next cycle, consumed at the following edge
    drive(1'b1, 16'd3, 16'd5, 16'd7);
    tick();
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    #1;
    check_head("one", 3, 5, 7);
    check("one_stall", 32'(stall), 32'd0);
    check("one_count", 32'(count), 32'd1);
    tick();
    check("one_cnt0", 32'(count), 32'd0);
    check("one_stall1", 32'(stall), 32'd1);
    check_head("one_empty", 0, 0, 0);
    check("one_scyc", 32'(stall_cycles), 32'd1);

    // Fill under hold: 4 accepted, 5th refused
    hold = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 16'(k), 16'(k + 1), 16'(k + 2));
      #1;
      check($sformatf("fill_ready%0d", k), 32'(in_ready), (k == 5) ? 32'd0 : 32'd1);
      tick();
    end
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    #1;
    check("fill_count", 32'(count), 32'd4);
    check("fill_stall", 32'(stall), 32'd1);
    check_head("fill_head", 1, 2, 3);
    hold = 1'b0;
    #1;
    for (int k = 1; k <= 4; k++) begin
      check_head($sformatf("drain%0d", k), k, k + 1, k + 2);
      check($sformatf("drain_stall%0d", k), 32'(stall), 32'd0);
      if (k == 2) check("drain_ready", 32'(in_ready), 32'd1);
      tick();
    end
    check("drain_count", 32'(count), 32'd0);

    // Streaming across pointer wrap: outputs lag inputs by one cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(100 + i), 16'(200 + i), 16'(300 + i));
      #1;
      if (i > 0) begin
        check_head($sformatf("wrap%0d", i), 100 + i - 1, 200 + i - 1, 300 + i - 1);
        check($sformatf("wrap_stall%0d", i), 32'(stall), 32'd0);
        check($sformatf("wrap_count%0d", i), 32'(count), 32'd1);
      end
      tick();
    end
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    #1;
    check_head("wrap_last", 109, 209, 309);
    tick();
    check("wrap_count_end", 32'(count), 32'd0);

    // Mid-operation reset with a push offered in the reset cycle
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'(40 + k), 16'(50 + k), 16'(60 + k));
      tick();
    end
    check("mrst_pre", 32'(count), 32'd3);
    drive(1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hold  = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 16'd0);
    #1;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_stall", 32'(stall), 32'd1);
    check("mrst_scyc", 32'(stall_cycles), 32'd0);
    check_head("mrst_head", 0, 0, 0);
    tick();
    check("mrst_count2", 32'(count), 32'd0);
    check_head("mrst_head2", 0, 0, 0);

    // Stall counter saturation
    hold = 1'b1;
    repeat (70000) tick();
    check("sat", 32'(stall_cycles), 32'hFFFF);
    repeat (5) tick();
    check("sat_hold", 32'(stall_cycles), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_issue_fifo.md
# operand_issue_fifo

Issue buffer directly upstream of the stalling arithmetic pipe. It accepts operand triples (a, b, c) over a valid/ready handshake and stores them in a small in-order FIFO. It presents the head triple to the pipe together with the pipe's `stall` input, and advances one triple per non-stall cycle. It also counts stall cycles for performance visibility and carries embedded formal properties in the same style as the pipe.

## Interface
- `WIDTH`, 16: bit width of each operand.
- `DEPTH`, 4: FIFO entries. Must be a power of two, at least 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  producer offers a triple this cycle.
- `in_ready`  output  1  FIFO can accept a triple this cycle.
- `in_a`, `in_b`, `in_c`  input  WIDTH  operand triple from the producer.
- `hold`  input  1  external freeze request from downstream control.
- `stall`  output  1  drives the pipe's `stall`.
- `a`, `b`, `c`  output  WIDTH  head triple, driven to the pipe.
- `count`  output  $clog2(DEPTH)+1  current occupancy.
- `stall_cycles`  output  16  saturating count of stalled cycles.

## Operation
- Storage: DEPTH × 3 × WIDTH array, read pointer, write pointer, occupancy counter. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push when `in_valid && in_ready`: write the triple at the write pointer, then increment the write pointer.
- `in_ready = (count != DEPTH)`. It is combinational and independent of a simultaneous pop. There is no full-bypass: when full, a push in the same cycle as a pop is refused.
- `stall = hold || (count == 0)`. It is combinational.
- Pop when `!stall`: the pipe samples `a`/`b`/`c` at this edge, and the read pointer increments.
- `a`/`b`/`c` = entry at the read pointer when `count != 0`; otherwise all zero. Outputs never show stale data while empty.
- Occupancy: count+1 on push only; count-1 on pop only; unchanged on push and pop together, or on neither.
- `stall_cycles`: increments on every cycle with `rst_n` high and `stall` high, and saturates at 16'hFFFF.
- `hold` high freezes the FIFO head. Pushes continue until full.
- Embedded formal properties, clocked, checked only when `rst_n` is high:
  - reset asserted exactly in the initial state;
  - `count <= DEPTH`;
  - `in_ready == (count != DEPTH)`;
  - `stall == (hold || count == 0)`;
  - `(count == 0)` implies a/b/c are zero;
  - `((wr_ptr - rd_ptr) mod DEPTH) == (count mod DEPTH)`.

## Timing
- Values on reset (rst_n low at an edge):
  - pointers 0, count 0, stall_cycles 0;
  - hence `stall` = 1, `in_ready` = 1, a/b/c = 0.
  - Storage contents are not reset.
- Reset mid-operation: all buffered triples are discarded at that edge. A push or pop in the reset cycle has no effect.
- Push-to-issue latency: 1 cycle. A triple pushed at edge N into an empty FIFO appears on a/b/c with `stall` low (hold low) in cycle N+1, and is consumed at edge N+1.
- Sustained throughput: one triple per cycle when the producer is always valid and `hold` is low. Occupancy stays at 1 after the first push.
- Full: `in_ready` is low for the whole cycle in which `count == DEPTH`. It rises in the cycle after a pop.
- Empty with `hold` low: `stall` stays high until the cycle after the first push.
- Wrap-around: order is preserved across pointer wrap. The triple following entry DEPTH-1 is read from entry 0.

## Test plan
- **Reset values:** hold rst_n low for 2 cycles, then release.
  - Required: stall=1, in_ready=1, count=0, a=b=c=0, stall_cycles=0 in the first cycle out of reset.
- **Single push:** push (a=3, b=5, c=7) with hold=0.
  - Required: next cycle a=3, b=5, c=7, stall=0.
  - Following cycle: count=0, stall=1, a=b=c=0.
- **Fill and stall:** hold=1, push 5 triples (k, k+1, k+2) for k=1..5.
  - Required: the first 4 are accepted, in_ready=0 on the 5th, count=4.
  - Release hold: k=1..4 issue in order on 4 consecutive cycles.
- **Wrap-around:** stream 10 triples with hold=0 and in_valid constant.
  - Required: outputs equal the inputs delayed by 1 cycle, with no bubbles and no reordering across the pointer wrap.
- **Mid-operation reset:** count=3, pulse rst_n low for 1 cycle together with in_valid=1.
  - Required: count=0, stall=1, and the pushed triple is dropped.
- **Counter saturation:** hold=1 for 70000 cycles.
  - Required: stall_cycles=16'hFFFF, and it stays there.
